// File: rtl/psum_readback.sv
// psum_readback
// Drains the partial-sum buffer once a layer has finished. Each 512-bit pixel
// word is fetched through the buffer's read port, which has a one-cycle read
// latency. The word is then serialized into a valid/ready stream of signed
// 32-bit channel results.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   start             one-cycle pulse that begins a frame; only honoured in IDLE
//   num_pix, num_ch   frame geometry, latched when start is accepted
//   busy, done        frame in progress / one-cycle completion pulse
//   rd_en, rd_addr    buffer read request (address = pixel index)
//   rd_data           buffer read data, valid the cycle after rd_en
//   m_valid, m_ready  output stream handshake
//   m_data, m_last    channel result and end-of-frame marker
module psum_readback #(
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_pix,
  input  logic [4:0]               num_ch,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last
);

  // Channel select width. The num_ch port is 5 bits wide, so NUM_CH is at
  // most 16 here, and the channel counter always fits in 5 bits.
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [4:0]      MAX_CH  = 5'(NUM_CH);
  localparam logic [ADDR_W:0] ONE_PIX = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND,
    S_FIN
  } state_t;

  state_t                        state, state_d;
  logic [ADDR_W-1:0]             pix, pix_d;
  logic [4:0]                    ch, ch_d;
  logic [ADDR_W:0]               num_pix_q, num_pix_d;
  logic [4:0]                    num_ch_q, num_ch_d;
  logic [NUM_CH-1:0][DATA_W-1:0] hold;
  logic                          last_pix;
  logic                          last_ch;

  // The end-of-pixel and end-of-frame tests are done at full width.
  // num_pix may equal 2^ADDR_W, and then the last index is 2^ADDR_W-1, so
  // the pixel counter never needs to wrap.
  assign last_pix = ({1'b0, pix} == (num_pix_q - ONE_PIX));
  assign last_ch  = (ch == (num_ch_q - 5'd1));

  // State, counters, latched configuration and the capture register.
  // Reset drops any word in flight and returns the block to an empty IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pix       <= '0;
      ch        <= '0;
      num_pix_q <= '0;
      num_ch_q  <= '0;
      hold      <= '0;
    end else begin
      state     <= state_d;
      pix       <= pix_d;
      ch        <= ch_d;
      num_pix_q <= num_pix_d;
      num_ch_q  <= num_ch_d;
      if (state == S_CAP) begin
        hold <= rd_data;
      end
    end
  end

  // Next-state logic. A pixel costs one RD cycle and one CAP cycle, then
  // one SEND cycle per accepted channel. An empty frame goes straight to FIN,
  // so the controller still sees done.
  always_comb begin
    state_d   = state;
    pix_d     = pix;
    ch_d      = ch;
    num_pix_d = num_pix_q;
    num_ch_d  = num_ch_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((num_pix != '0) && (num_ch != '0)) begin
            num_pix_d = num_pix;
            num_ch_d  = (num_ch > MAX_CH) ? MAX_CH : num_ch;
            pix_d     = '0;
            ch_d      = '0;
            state_d   = S_RD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = S_SEND;
      S_SEND: begin
        if (m_ready) begin
          if (!last_ch) begin
            ch_d = ch + 5'd1;
          end else if (!last_pix) begin
            pix_d   = pix + 1'b1;
            ch_d    = '0;
            state_d = S_RD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state. While SEND waits on m_ready, the
  // held word and the counters are frozen, so m_data and m_last stay stable.
  assign busy    = (state == S_RD) || (state == S_CAP) || (state == S_SEND);
  assign done    = (state == S_FIN);
  assign rd_en   = (state == S_RD);
  assign rd_addr = (state == S_RD) ? pix : '0;
  assign m_valid = (state == S_SEND);
  assign m_data  = (state == S_SEND) ? hold[ch[IDX_W-1:0]] : '0;
  assign m_last  = m_valid && last_pix && last_ch;

endmodule

// File: tb/tb_psum_readback.sv
// Self-checking bench for psum_readback.
// The bench holds a behavioural buffer memory with one-cycle read latency.
// For every frame it builds the expected word stream and read-address list
// directly from the frame geometry and the memory contents. A single compare
// process checks the DUT against those lists on every falling edge.
module tb_psum_readback;

  localparam int ADDR_W = 10;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 32;
  localparam int WORD_W = NUM_CH * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_pix = '0;
  logic [4:0]        num_ch = '0;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  logic [WORD_W-1:0] mem [DEPTH];
  exp_t              exp_q[$];
  int                addr_q[$];
  logic [DATA_W-1:0] obs_data [64];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, first_rd_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int done_count, pop_count;
  bit prev_stall = 1'b0;
  bit rand_mode = 1'b0;

  psum_readback #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_pix (num_pix),
    .num_ch  (num_ch),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  initial forever #5 clk = ~clk;

  // Cycle counter used to measure latencies.
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: the word is presented one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Downstream ready: either held high or about 50% random.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Compare process: reads, stream words, stall stability and done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (addr_q.size() == 0) check("unexpected rd_en", 1, 0);
        else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
      end
      if (prev_stall) check("m_valid held through stall", m_valid, 1);
      if (m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("busy during send", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected m_valid", 1, 0);
        end else begin
          check("m_data", m_data, exp_q[0].data);
          check("m_last", m_last, exp_q[0].last);
          if (m_ready) begin
            if (pop_count < 64) obs_data[pop_count] = m_data;
            pop_count++;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) last_hs_cyc = cyc;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("busy low at done", busy, 0);
      end
    end
  end

  task automatic check_output(string name);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " rd_en"}, rd_en, 0);
    check({name, " rd_addr"}, 64'(rd_addr), 0);
    check({name, " m_valid"}, m_valid, 0);
    check({name, " m_data"}, m_data, 0);
    check({name, " m_last"}, m_last, 0);
  endtask

  // Runs one frame.
  //   mode 0 = plain run
  //   mode 1 = a start pulse (num_pix=7) is injected during SEND of pixel 1
  //   mode 2 = reset is asserted during SEND of pixel 2
  task automatic apply_stimulus(int np, int nc, bit rnd, int mode);
    int  ch_eff;
    int  budget;
    bit  aborted;
    bit  injected;
    ch_eff = (nc > NUM_CH) ? NUM_CH : nc;
    exp_q.delete();
    addr_q.delete();
    if (np > 0 && ch_eff > 0) begin
      for (int k = 0; k < np; k++) begin
        addr_q.push_back(k);
        for (int c = 0; c < ch_eff; c++)
          exp_q.push_back('{data: mem[k][c*DATA_W +: DATA_W],
                             last: (k == np - 1) && (c == ch_eff - 1)});
      end
    end
    first_rd_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_count = 0; pop_count = 0;
    rand_mode = rnd;
    @(posedge clk); #1;
    num_pix = (ADDR_W+1)'(np);
    num_ch = 5'(nc);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    aborted = 1'b0;
    injected = 1'b0;
    budget = np * (ch_eff + 2) * (rnd ? 8 : 1) + 20;
    for (int i = 0; i < budget && done_count == 0 && !aborted; i++) begin
      if (mode == 1) begin
        if (!injected && pop_count > ch_eff && m_valid) begin
          num_pix = 11'd7;
          start = 1'b1;
          injected = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      if (mode == 2 && pop_count > 2 * ch_eff && m_valid) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("mid-frame reset");
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        aborted = 1'b1;
      end
      if (!aborted) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    rand_mode = 1'b0;
    if (mode == 2) begin
      check("reset reached pixel 2", aborted, 1);
    end else begin
      if (done_count == 0) check("done timeout", 0, 1);
      repeat (4) @(posedge clk);
      #1;
      if (mode == 1) check("start injected", injected, 1);
      check("done pulse count", done_count, 1);
      check("words outstanding", exp_q.size(), 0);
      check("reads outstanding", addr_q.size(), 0);
      if (np == 0 || ch_eff == 0) begin
        check("empty done latency", done_cyc, start_cyc + 1);
        check("empty no rd_en", first_rd_cyc, -1);
        check("empty no m_valid", first_valid_cyc, -1);
      end else begin
        check("done after last word", done_cyc, last_hs_cyc + 1);
        check("rd_en latency", first_rd_cyc, start_cyc + 1);
        check("m_valid latency", first_valid_cyc, start_cyc + 3);
        if (!rnd) check("frame cycles", last_hs_cyc - first_rd_cyc + 1, np * (ch_eff + 2));
      end
    end
  endtask

  logic [DATA_W-1:0] pats [3];

  initial begin
    pats[0] = 32'h8000_0000;
    pats[1] = 32'hFFFF_FFFF;
    pats[2] = 32'h7FFF_FFFF;
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < NUM_CH; c++)
        mem[k][c*DATA_W +: DATA_W] = DATA_W'(k * 100 + c);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset");
    rst_n = 1'b1;

    $display("[TB] basic frame 4x10");
    apply_stimulus(4, 10, 1'b0, 0);
    check("basic count", pop_count, 40);
    check("basic word 0", obs_data[0], 0);
    check("basic word 9", obs_data[9], 9);
    check("basic word 10", obs_data[10], 100);
    check("basic word 39", obs_data[39], 309);
    check("basic 48 cycles", last_hs_cyc - first_rd_cyc + 1, 48);

    $display("[TB] backpressure frame 4x10");
    apply_stimulus(4, 10, 1'b1, 0);
    check("bp count", pop_count, 40);
    check("bp word 21", obs_data[21], 201);
    check("bp word 39", obs_data[39], 309);

    $display("[TB] start while busy");
    apply_stimulus(3, 4, 1'b0, 1);
    check("busy-start count", pop_count, 12);

    $display("[TB] empty frames");
    apply_stimulus(0, 10, 1'b0, 0);
    apply_stimulus(4, 0, 1'b0, 0);

    $display("[TB] full address range");
    apply_stimulus(DEPTH, 1, 1'b0, 0);
    check("full range count", pop_count, DEPTH);

    $display("[TB] reset mid-frame then restart");
    apply_stimulus(4, 5, 1'b0, 2);
    apply_stimulus(3, 4, 1'b0, 0);
    check("restart word 0", obs_data[0], 0);
    check("restart word 4", obs_data[4], 100);

    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NUM_CH; c++)
        mem[k][c*DATA_W +: DATA_W] = pats[(c + k) % 3];
    for (int n = 16; n <= 20; n += 4) begin
      $display("[TB] full width and sign, num_ch=%0d", n);
      apply_stimulus(2, n, 1'b0, 0);
      check("sign count", pop_count, 32);
      check("sign word 0", obs_data[0], 32'h8000_0000);
      check("sign word 1", obs_data[1], 32'hFFFF_FFFF);
      check("sign word 2", obs_data[2], 32'h7FFF_FFFF);
      check("sign word 15", obs_data[15], 32'h8000_0000);
      check("sign word 16", obs_data[16], 32'hFFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
